// File: rtl/dmem_responder_g7_pkg.sv
// Shared definitions for the dmem_responder_g7 slice.
// Holds the access-size encodings, the responder FSM states, the latched
// request record and a 16-bit saturating increment used by the optional
// access counters.
package dmem_responder_g7_pkg;

  localparam logic [1:0] DMEM_SIZE_B = 2'd0;
  localparam logic [1:0] DMEM_SIZE_H = 2'd1;
  localparam logic [1:0] DMEM_SIZE_W = 2'd2;

  typedef enum logic [1:0] {
    DMEM_IDLE = 2'd0,
    DMEM_WAIT = 2'd1,
    DMEM_RESP = 2'd2
  } dmem_state_e;

  typedef struct packed {
    logic        write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [1:0]  size;
    logic        is_unsigned;
  } dmem_req_t;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == '1) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/dmem_responder_g7_lane_align.sv
// dmem_lane_align_g7: combinational byte-lane steering for the responder.
// Ports:
//   addr_lo     in  2   byte offset within the addressed word
//   size        in  2   access size (B/H/W, 3 = illegal)
//   is_unsigned in  1   zero-extend sub-word loads when 1
//   wdata       in  32  store data, LSB-aligned
//   rword       in  32  word currently held at the addressed word slot
//   byte_en     out 4   store byte-enable mask
//   wlane       out 32  store data replicated onto the addressed lanes
//   rdata_ext   out 32  extended load data
//   misaligned  out 1   halfword/word not naturally aligned
//   bad_size    out 1   size encoding 3
module dmem_lane_align_g7
  import dmem_responder_g7_pkg::*;
(
  input  logic [1:0]  addr_lo,
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  input  logic [31:0] wdata,
  input  logic [31:0] rword,
  output logic [3:0]  byte_en,
  output logic [31:0] wlane,
  output logic [31:0] rdata_ext,
  output logic        misaligned,
  output logic        bad_size
);

  logic [15:0] rshift;

  always_comb begin
    // Addressed byte/halfword moved down to bit 0 before extension.
    rshift     = 16'(rword >> {addr_lo, 3'b000});
    byte_en    = '0;
    wlane      = '0;
    rdata_ext  = '0;
    misaligned = 1'b0;
    bad_size   = 1'b0;
    case (size)
      DMEM_SIZE_B: begin
        byte_en   = 4'b0001 << addr_lo;
        wlane     = {4{wdata[7:0]}};
        rdata_ext = {{24{~is_unsigned & rshift[7]}}, rshift[7:0]};
      end
      DMEM_SIZE_H: begin
        misaligned = addr_lo[0];
        byte_en    = 4'b0011 << addr_lo;
        wlane      = {2{wdata[15:0]}};
        rdata_ext  = {{16{~is_unsigned & rshift[15]}}, rshift[15:0]};
      end
      DMEM_SIZE_W: begin
        misaligned = (addr_lo != 2'b00);
        byte_en    = '1;
        wlane      = wdata;
        rdata_ext  = rword;
      end
      default: bad_size = 1'b1;
    endcase
  end

endmodule

// File: rtl/dmem_responder_g7.sv
// dmem_responder_g7: handshaked data-memory responder for the RV32 load/store
// port. One request at a time, response after WAIT_CYCLES extra cycles.
// Parameters: MEM_BYTES (power of two, >= 4), WAIT_CYCLES (0..15).
// Ports:
//   clk, rst (async active-low)
//   req_valid/req_ready  request handshake; req_write, req_addr, req_wdata,
//                        req_size, req_unsigned sampled on the accept cycle
//   rsp_valid/rsp_ready  response handshake; rsp_rdata, rsp_err held stable
//   cnt_loads/cnt_stores/cnt_errors (16-bit, saturating) exist only when
//   DMEM_ACCESS_CNT_EN is defined.
module dmem_responder_g7
  import dmem_responder_g7_pkg::*;
#(
  parameter int unsigned MEM_BYTES   = 1024,
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
`ifdef DMEM_ACCESS_CNT_EN
  ,
  output logic [15:0] cnt_loads,
  output logic [15:0] cnt_stores,
  output logic [15:0] cnt_errors
`endif
);

  localparam int unsigned AW        = $clog2(MEM_BYTES);
  localparam int unsigned WORDS     = MEM_BYTES / 4;
  localparam int unsigned IW        = (AW > 2) ? AW - 2 : 1;
  localparam logic [3:0]  WAIT_INIT = 4'(WAIT_CYCLES);
  localparam bit          NO_WAIT   = (WAIT_CYCLES == 0);

  dmem_state_e state_q, state_d;
  logic [3:0]  wait_cnt;
  dmem_req_t   req_q, req_live, op;
  logic        accept, rsp_hs, do_access, fault, addr_oob;
  logic [IW-1:0] widx;
  logic [31:0] rword, wlane, rdata_ext;
  logic [3:0]  byte_en;
  logic        misaligned, bad_size;

  logic [31:0] mem [WORDS];

  assign req_live = '{write: req_write, addr: req_addr, wdata: req_wdata,
                      size: req_size, is_unsigned: req_unsigned};

  // With no wait the access happens on the accept edge itself, so the
  // live request is used in IDLE and the latched copy afterwards.
  assign op       = (state_q == DMEM_IDLE) ? req_live : req_q;
  assign addr_oob = ((op.addr >> AW) != 32'd0);
  assign widx     = IW'(op.addr >> 2);
  assign rword    = mem[widx];
  assign fault    = bad_size | misaligned | addr_oob;

  dmem_lane_align_g7 u_align (
    .addr_lo     (op.addr[1:0]),
    .size        (op.size),
    .is_unsigned (op.is_unsigned),
    .wdata       (op.wdata),
    .rword       (rword),
    .byte_en     (byte_en),
    .wlane       (wlane),
    .rdata_ext   (rdata_ext),
    .misaligned  (misaligned),
    .bad_size    (bad_size)
  );

  always_comb begin
    state_d   = state_q;
    req_ready = (state_q == DMEM_IDLE);
    rsp_valid = (state_q == DMEM_RESP);
    accept    = req_valid & req_ready;
    rsp_hs    = rsp_valid & rsp_ready;
    case (state_q)
      DMEM_IDLE: if (accept) state_d = NO_WAIT ? DMEM_RESP : DMEM_WAIT;
      DMEM_WAIT: if (wait_cnt == 4'd1) state_d = DMEM_RESP;
      DMEM_RESP: if (rsp_ready) state_d = DMEM_IDLE;
      default:   state_d = DMEM_IDLE;
    endcase
    // The storage array has no reset; gating with rst keeps a request
    // presented during reset from committing.
    do_access = rst & (state_q != DMEM_RESP) & (state_d == DMEM_RESP);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= DMEM_IDLE;
      wait_cnt  <= '0;
      req_q     <= '0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        req_q    <= req_live;
        wait_cnt <= WAIT_INIT;
      end else if (state_q == DMEM_WAIT) begin
        wait_cnt <= wait_cnt - 4'd1;
      end
      if (do_access) begin
        rsp_err   <= fault;
        rsp_rdata <= (fault | op.write) ? '0 : rdata_ext;
      end else if (rsp_hs) begin
        rsp_rdata <= '0;
        rsp_err   <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (do_access && op.write && !fault) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (byte_en[i]) mem[widx][8*i +: 8] <= wlane[8*i +: 8];
      end
    end
  end

`ifdef DMEM_ACCESS_CNT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_loads  <= '0;
      cnt_stores <= '0;
      cnt_errors <= '0;
    end else if (rsp_hs) begin
      if (rsp_err)          cnt_errors <= sat_inc16(cnt_errors);
      else if (req_q.write) cnt_stores <= sat_inc16(cnt_stores);
      else                  cnt_loads  <= sat_inc16(cnt_loads);
    end
  end
`endif

endmodule

// File: tb/tb_dmem_responder_g7.sv
`timescale 1ns/1ps
module tb_dmem_responder_g7;

  localparam int unsigned MEMB = 1024;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        req_valid [2];
  logic        req_ready [2];
  logic        req_write [2];
  logic [31:0] req_addr  [2];
  logic [31:0] req_wdata [2];
  logic [1:0]  req_size  [2];
  logic        req_unsigned [2];
  logic        rsp_valid [2];
  logic        rsp_ready [2];
  logic [31:0] rsp_rdata [2];
  logic        rsp_err   [2];
`ifdef DMEM_ACCESS_CNT_EN
  logic [15:0] cnt_loads [2], cnt_stores [2], cnt_errors [2];
`endif

  // Index 0: WAIT_CYCLES=0, index 1: WAIT_CYCLES=3.
  dmem_responder_g7 #(.MEM_BYTES(MEMB), .WAIT_CYCLES(0)) u_w0 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_write(req_write[0]),
    .req_addr(req_addr[0]), .req_wdata(req_wdata[0]), .req_size(req_size[0]),
    .req_unsigned(req_unsigned[0]), .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
    .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0])
`ifdef DMEM_ACCESS_CNT_EN
    , .cnt_loads(cnt_loads[0]), .cnt_stores(cnt_stores[0]), .cnt_errors(cnt_errors[0])
`endif
  );

  dmem_responder_g7 #(.MEM_BYTES(MEMB), .WAIT_CYCLES(3)) u_w3 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_write(req_write[1]),
    .req_addr(req_addr[1]), .req_wdata(req_wdata[1]), .req_size(req_size[1]),
    .req_unsigned(req_unsigned[1]), .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
    .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1])
`ifdef DMEM_ACCESS_CNT_EN
    , .cnt_loads(cnt_loads[1]), .cnt_stores(cnt_stores[1]), .cnt_errors(cnt_errors[1])
`endif
  );

  typedef struct {
    string       name;
    logic [31:0] rdata;
    logic        err;
  } rsp_t;

  typedef struct {
    string       name;
    logic [31:0] act;
    logic [31:0] exp;
  } chk_t;

  rsp_t exp_q0 [$];
  rsp_t exp_q1 [$];
  chk_t chk_q  [$];

  int n_cmp  = 0;
  int n_fail = 0;
  int unsigned m_loads [2] = '{0, 0};
  int unsigned m_stores[2] = '{0, 0};
  int unsigned m_errs  [2] = '{0, 0};

  task automatic push_chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_t c;
    c.name = name;
    c.act  = act;
    c.exp  = exp;
    chk_q.push_back(c);
  endtask

  // Monitor: drains queued point checks and scores every response handshake.
  always @(negedge clk) begin
    chk_t c;
    rsp_t r;
    while (chk_q.size() > 0) begin
      c = chk_q.pop_front();
      n_cmp++;
      if (c.act !== c.exp) begin
        n_fail++;
        $display("FAIL %s: got %h, want %h", c.name, c.act, c.exp);
      end
    end
    for (int d = 0; d < 2; d++) begin
      if (rsp_valid[d] === 1'b1 && rsp_ready[d] === 1'b1) begin
        if ((d == 0 && exp_q0.size() == 0) || (d == 1 && exp_q1.size() == 0)) begin
          n_cmp++;
          n_fail++;
          $display("FAIL unexpected_rsp dut%0d: got rdata %h err %b, want no response",
                   d, rsp_rdata[d], rsp_err[d]);
        end else begin
          if (d == 0) r = exp_q0.pop_front();
          else        r = exp_q1.pop_front();
          n_cmp++;
          if (rsp_rdata[d] !== r.rdata) begin
            n_fail++;
            $display("FAIL %s_rdata dut%0d: got %h, want %h", r.name, d, rsp_rdata[d], r.rdata);
          end
          n_cmp++;
          if (rsp_err[d] !== r.err) begin
            n_fail++;
            $display("FAIL %s_err dut%0d: got %b, want %b", r.name, d, rsp_err[d], r.err);
          end
        end
      end
    end
  end

  // Issue one transaction on DUT d; called #1 after a rising edge with DUT idle.
  task automatic issue(input int d, input logic wr, input logic [1:0] sz, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wd,
                       input logic [31:0] exp_rd, input logic exp_er,
                       input int hold, input string name);
    rsp_t e;
    int   lat;
    int   guard;
    int   exp_lat;
    exp_lat = (d == 0) ? 1 : 4;
    e.name  = name;
    e.rdata = exp_rd;
    e.err   = exp_er;
    if (d == 0) exp_q0.push_back(e);
    else        exp_q1.push_back(e);
    if (exp_er)  m_errs[d]++;
    else if (wr) m_stores[d]++;
    else         m_loads[d]++;

    req_write[d]    = wr;
    req_size[d]     = sz;
    req_unsigned[d] = uns;
    req_addr[d]     = addr;
    req_wdata[d]    = wd;
    req_valid[d]    = 1'b1;
    rsp_ready[d]    = (hold == 0);
    guard = 0;
    @(negedge clk);
    while (req_ready[d] !== 1'b1 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 20) push_chk({name, "_accept_timeout"}, 32'd1, 32'd0);
    @(posedge clk); #1;
    // Scramble request inputs after the accept edge; they must be ignored.
    req_valid[d]    = 1'b0;
    req_write[d]    = 1'($urandom);
    req_size[d]     = 2'($urandom);
    req_unsigned[d] = 1'($urandom);
    req_addr[d]     = $urandom;
    req_wdata[d]    = $urandom;

    lat = 1;
    while (rsp_valid[d] !== 1'b1 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    push_chk({name, "_latency"}, 32'(lat), 32'(exp_lat));

    for (int i = 0; i < hold; i++) begin
      push_chk({name, "_hold_valid"},     32'(rsp_valid[d]), 32'd1);
      push_chk({name, "_hold_rdata"},     rsp_rdata[d],      exp_rd);
      push_chk({name, "_hold_err"},       32'(rsp_err[d]),   32'(exp_er));
      push_chk({name, "_hold_req_ready"}, 32'(req_ready[d]), 32'd0);
      @(posedge clk); #1;
    end
    rsp_ready[d] = 1'b1;
    @(posedge clk); #1;
    push_chk({name, "_valid_drop"}, 32'(rsp_valid[d]), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b0;
    for (int d = 0; d < 2; d++) begin
      req_valid[d]    = 1'b0;
      req_write[d]    = 1'b0;
      req_size[d]     = 2'd0;
      req_unsigned[d] = 1'b0;
      req_addr[d]     = '0;
      req_wdata[d]    = '0;
      rsp_ready[d]    = 1'b1;
    end
    repeat (2) @(posedge clk); #1;
    for (int d = 0; d < 2; d++) begin
      push_chk("reset_req_ready", 32'(req_ready[d]), 32'd1);
      push_chk("reset_rsp_valid", 32'(rsp_valid[d]), 32'd0);
      push_chk("reset_rsp_rdata", rsp_rdata[d], 32'd0);
      push_chk("reset_rsp_err",   32'(rsp_err[d]),   32'd0);
    end
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;

    // Known word at 0x20, then a store aborted by reset mid-WAIT.
    issue(1, 1'b1, 2'd2, 1'b0, 32'h20, 32'h1122_3344, 32'h0, 1'b0, 0, "sw_pre20");
    req_write[1] = 1'b1; req_size[1] = 2'd2; req_unsigned[1] = 1'b0;
    req_addr[1]  = 32'h20; req_wdata[1] = 32'hCAFE_BABE; req_valid[1] = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    req_valid[1] = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    push_chk("midwait_rst_rsp_valid", 32'(rsp_valid[1]), 32'd0);
    push_chk("midwait_rst_req_ready", 32'(req_ready[1]), 32'd1);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    issue(1, 1'b0, 2'd2, 1'b0, 32'h20, 32'h0, 32'h1122_3344, 1'b0, 0, "lw20_after_abort");

    // Word store/load at both wait settings.
    issue(0, 1'b1, 2'd2, 1'b0, 32'h10, 32'h8001_7F80, 32'h0, 1'b0, 0, "w0_sw10");
    issue(0, 1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 32'h8001_7F80, 1'b0, 0, "w0_lw10");
    issue(1, 1'b1, 2'd2, 1'b0, 32'h10, 32'h8001_7F80, 32'h0, 1'b0, 0, "w3_sw10");
    issue(1, 1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 32'h8001_7F80, 1'b0, 0, "w3_lw10");

    // Sub-word loads.
    issue(1, 1'b0, 2'd0, 1'b0, 32'h10, 32'h0, 32'hFFFF_FF80, 1'b0, 0, "lb10");
    issue(1, 1'b0, 2'd0, 1'b1, 32'h10, 32'h0, 32'h0000_0080, 1'b0, 0, "lbu10");
    issue(1, 1'b0, 2'd1, 1'b0, 32'h12, 32'h0, 32'hFFFF_8001, 1'b0, 0, "lh12");
    issue(1, 1'b0, 2'd1, 1'b1, 32'h12, 32'h0, 32'h0000_8001, 1'b0, 0, "lhu12");
    issue(0, 1'b0, 2'd0, 1'b0, 32'h11, 32'h0, 32'h0000_007F, 1'b0, 0, "w0_lb11");
    issue(1, 1'b0, 2'd2, 1'b1, 32'h10, 32'h0, 32'h8001_7F80, 1'b0, 0, "lw10_uns_ignored");

    // Sub-word stores over a zeroed word.
    issue(1, 1'b1, 2'd2, 1'b0, 32'h14, 32'h0, 32'h0, 1'b0, 0, "sw14_zero");
    issue(1, 1'b1, 2'd0, 1'b0, 32'h15, 32'h1234_56AA, 32'h0, 1'b0, 0, "sb15");
    issue(1, 1'b1, 2'd1, 1'b0, 32'h16, 32'hABCD_1234, 32'h0, 1'b0, 0, "sh16");
    issue(1, 1'b0, 2'd2, 1'b0, 32'h14, 32'h0, 32'h1234_AA00, 1'b0, 0, "lw14");

    // Last word of storage, and the first address past it.
    issue(1, 1'b1, 2'd2, 1'b0, MEMB - 4, 32'h5A5A_0001, 32'h0, 1'b0, 0, "sw_last");
    issue(1, 1'b0, 2'd2, 1'b0, MEMB - 4, 32'h0, 32'h5A5A_0001, 1'b0, 0, "lw_last");
    issue(1, 1'b0, 2'd0, 1'b0, MEMB - 1, 32'h0, 32'h0000_005A, 1'b0, 0, "lb_last");
    issue(1, 1'b0, 2'd0, 1'b0, MEMB,     32'h0, 32'h0, 1'b1, 0, "lb_oob");

    // Faults, one with backpressure.
    issue(1, 1'b0, 2'd1, 1'b0, 32'h11, 32'h0, 32'h0, 1'b1, 2, "lh11_misal");
    issue(1, 1'b0, 2'd2, 1'b0, 32'h22, 32'h0, 32'h0, 1'b1, 0, "lw22_misal");
    issue(1, 1'b1, 2'd2, 1'b0, MEMB,   32'hDEAD_BEEF, 32'h0, 1'b1, 0, "sw_oob");
    issue(1, 1'b1, 2'd2, 1'b0, 32'h22, 32'hDEAD_BEEF, 32'h0, 1'b1, 0, "sw22_misal");
    issue(1, 1'b1, 2'd3, 1'b0, 32'h20, 32'hDEAD_BEEF, 32'h0, 1'b1, 0, "st_size3");
    issue(1, 1'b0, 2'd3, 1'b0, 32'h10, 32'h0, 32'h0, 1'b1, 0, "ld_size3");
    issue(0, 1'b0, 2'd2, 1'b0, 32'h11, 32'h0, 32'h0, 1'b1, 0, "w0_lw11_misal");
    issue(1, 1'b0, 2'd2, 1'b0, 32'h20, 32'h0, 32'h1122_3344, 1'b0, 0, "lw20_unchanged");

    // Backpressure on a good load.
    issue(1, 1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 32'h8001_7F80, 1'b0, 5, "lw10_backpressure");

    push_chk("exp_q0_empty", 32'(exp_q0.size()), 32'd0);
    push_chk("exp_q1_empty", 32'(exp_q1.size()), 32'd0);
`ifdef DMEM_ACCESS_CNT_EN
    for (int d = 0; d < 2; d++) begin
      push_chk("cnt_loads",  32'(cnt_loads[d]),  m_loads[d]);
      push_chk("cnt_stores", 32'(cnt_stores[d]), m_stores[d]);
      push_chk("cnt_errors", 32'(cnt_errors[d]), m_errs[d]);
    end
`endif
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/dmem_responder_g7.md
Name: dmem_responder_g7

Overview:
Handshaked data-memory responder for the RV32 core's load/store port. It accepts one request at a time on a valid/ready request channel and returns a response after a fixed, parameterised wait. It performs byte, halfword and word accesses, with sign or zero extension on loads. It is the memory-side end of the load/store interface and lets the core and testbenches model multi-cycle memory.

Parameters:
MEM_BYTES, 1024, storage size in bytes; must be a power of two and at least 4.
WAIT_CYCLES, 1, extra cycles between request acceptance and response; legal range 0..15.

Ports:
clk  in  1  rising-edge clock
rst  in  1  asynchronous, active-low reset (0 = reset asserted)
req_valid  in  1  request present
req_ready  out  1  responder can accept a request
req_write  in  1  1 = store, 0 = load
req_addr  in  32  byte address
req_wdata  in  32  store data; stored bits are taken LSB-aligned
req_size  in  2  0 = byte, 1 = halfword, 2 = word, 3 = illegal
req_unsigned  in  1  load zero-extends when 1, sign-extends when 0
rsp_valid  out  1  response present
rsp_ready  in  1  consumer accepts the response
rsp_rdata  out  32  load result; 0 for stores and for errors
rsp_err  out  1  access faulted

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, wait counter=0.
  - Memory contents are not cleared.
  - Reset during WAIT or RESP drops the pending request. A store that has not yet committed is never written.
- FSM states: IDLE, WAIT, RESP.
  - req_ready=1 only in IDLE. A request is accepted when req_valid & req_ready.
- IDLE:
  - On accept, latch write, addr, wdata, size and unsigned; load counter=WAIT_CYCLES.
  - Go to WAIT if WAIT_CYCLES>0, else go to RESP.
- WAIT:
  - Counter decrements each cycle.
  - On the cycle the counter reaches 1, perform the access and go to RESP.
- RESP:
  - rsp_valid=1; rsp_rdata and rsp_err stay stable until rsp_ready=1.
  - On rsp_valid & rsp_ready: go to IDLE; rsp_valid=0 next cycle.
  - No new request is accepted in the same cycle as the response handshake (req_ready is 0 in RESP).
- Latency: rsp_valid rises exactly WAIT_CYCLES+1 cycles after the accept edge. Minimum throughput is one transaction per WAIT_CYCLES+2 cycles.
- Access is performed on the transition into RESP.
  - Stores commit then, touching only the addressed bytes.
  - Load data is registered then.
- Memory is little-endian; byte k of a word is stored at address+k.
- Error conditions (rsp_err=1, no write, rsp_rdata=0):
  - req_size=3;
  - halfword access with addr[0]=1;
  - word access with addr[1:0]!=0;
  - addr >= MEM_BYTES (no wrap-around).
- Loads:
  - Byte: bits [31:8] = sign of the loaded byte, or 0 when unsigned.
  - Halfword: bits [31:16] filled the same way.
  - Word: req_unsigned is ignored.
- Store followed by a load to the same address returns the new data; no hazard is visible because transactions are serialised.
- req_* inputs are ignored outside the accept cycle.

Optional Feature:
DMEM_ACCESS_CNT_EN
- Defined: adds outputs cnt_loads, cnt_stores and cnt_errors, each 16 bits.
  - Each counter increments by 1 at the response handshake of a matching transaction.
  - Erroring transactions count only in cnt_errors.
  - Counters saturate at 16'hFFFF and reset to 0.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Decomposition:
- Shared package or defines file holds:
  - size encodings DMEM_SIZE_B=2'd0, DMEM_SIZE_H=2'd1, DMEM_SIZE_W=2'd2;
  - FSM state encodings DMEM_IDLE, DMEM_WAIT, DMEM_RESP.
- One natural sub-module, dmem_lane_align_g7 (combinational):
  - from addr[1:0], size and unsigned, produces the store byte-enable mask, store lane data and extended load data;
  - also flags misalignment.
- The FSM, counter, storage and the optional counters live in the top block.

Test Plan:
- Reset mid-WAIT: store W 0x20=0xCAFEBABE is accepted; rst=0 pulses before RESP -> rsp_valid=0, req_ready=1. A later load W 0x20 returns the pre-existing value, not 0xCAFEBABE.
- WAIT_CYCLES=0 and WAIT_CYCLES=3: store W 0x10=0x8001_7F80, then load W 0x10 -> rdata=0x80017F80, err=0. rsp_valid rises 1 and 4 cycles after accept respectively.
- Sub-word loads from 0x10 after the store above:
  - LB 0x10 -> 0xFFFFFF80; LBU 0x10 -> 0x00000080;
  - LH 0x12 -> 0xFFFF8001; LHU 0x12 -> 0x00008001.
- Sub-word stores: SB 0x15=0xAA, then SH 0x16=0x1234 over a word preset to 0 -> LW 0x14 = 0x1234AA00.
- Errors: LH 0x11, LW 0x22, SW at MEM_BYTES, and size=3 each give err=1, rdata=0. The erroring SW leaves memory unchanged.
- Backpressure: rsp_ready held 0 for 5 cycles -> rsp_valid, rsp_rdata and rsp_err stay stable; req_ready=0 throughout. With DMEM_ACCESS_CNT_EN defined, counters match the issued transaction mix.
